// File: rtl/lb_timer.sv
`default_nettype none
// ============================================================================
// Module   : lb_timer (with lb_pkg)
// Brief    : LB-bus responder hosting a prescaled 32-bit timer with compare
//            match, level interrupt and optional capture input
//            (enabled by defining LB_TIMER_CAPTURE_EN).
// Revision : 1.0 - initial release
// ============================================================================

package lb_pkg;
    localparam int LB_ADDR_WIDTH = 16;

    typedef struct packed {
        logic                     ren;
        logic                     wen;
        logic [LB_ADDR_WIDTH-1:0] addr;
        logic [31:0]              wdata;
        logic [1:0]               write_width;
    } lb_slave_t;
endpackage

module lb_timer
    import lb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        lb_clk,
    input  logic        rst_n,
    input  lb_slave_t   bus,
`ifdef LB_TIMER_CAPTURE_EN
    input  logic        cap_in,
`endif
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [2:0] c_CTRL     = 3'd0;
    localparam logic [2:0] c_PRESCALE = 3'd1;
    localparam logic [2:0] c_COMPARE  = 3'd2;
    localparam logic [2:0] c_COUNT    = 3'd3;
    localparam logic [2:0] c_STATUS   = 3'd4;
    localparam logic [2:0] c_CAPTURE  = 3'd5;

    logic [3:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_compare;
    logic [31:0]           r_count;
    logic                  r_match;
    logic [PRESCALE_W-1:0] r_pcnt;

    logic        w_hit;
    logic [2:0]  w_idx;
    logic        w_rd;
    logic        w_wr;
    logic        w_wvalid;
    logic [31:0] w_wmask;
    logic [31:0] w_wdata_al;
    logic [31:0] w_cur;
    logic [31:0] w_merged;
    logic [31:0] w_w1c;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_wr_cmp;
    logic        w_wr_cnt;
    logic        w_wr_sts;
    logic        w_tick;
    logic        w_match_ev;
    logic [31:0] w_capture;
    logic        w_cap_flag;

    assign w_hit = (bus.addr[LB_ADDR_WIDTH-1:5] == BASE_ADDR[LB_ADDR_WIDTH-1:5]);
    assign w_idx = bus.addr[4:2];
    assign w_rd  = bus.ren & w_hit;

    // Align the write value onto its byte lanes; misaligned halves are dropped.
    always_comb begin
        w_wmask    = 32'h0;
        w_wdata_al = 32'h0;
        w_wvalid   = 1'b0;
        case (bus.write_width)
            2'b00: begin
                w_wmask    = 32'h0000_00FF << {bus.addr[1:0], 3'b000};
                w_wdata_al = {24'h0, bus.wdata[7:0]} << {bus.addr[1:0], 3'b000};
                w_wvalid   = 1'b1;
            end
            2'b01: begin
                if (!bus.addr[0]) begin
                    w_wmask    = 32'h0000_FFFF << {bus.addr[1], 4'b0000};
                    w_wdata_al = {16'h0, bus.wdata[15:0]} << {bus.addr[1], 4'b0000};
                    w_wvalid   = 1'b1;
                end
            end
            default: begin
                w_wmask    = 32'hFFFF_FFFF;
                w_wdata_al = bus.wdata;
                w_wvalid   = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_cur = 32'h0;
        case (w_idx)
            c_CTRL:     w_cur = {28'h0, r_ctrl};
            c_PRESCALE: w_cur = 32'(r_prescale);
            c_COMPARE:  w_cur = r_compare;
            c_COUNT:    w_cur = r_count;
            c_STATUS:   w_cur = {30'h0, w_cap_flag, r_match};
            c_CAPTURE:  w_cur = w_capture;
            default:    w_cur = 32'h0;
        endcase
    end

    assign rdata     = w_rd ? w_cur : 32'h0;
    assign w_merged  = (w_cur & ~w_wmask) | (w_wdata_al & w_wmask);
    assign w_w1c     = w_wdata_al & w_wmask;

    assign w_wr      = bus.wen & w_hit & w_wvalid;
    assign w_wr_ctrl = w_wr && (w_idx == c_CTRL);
    assign w_wr_pre  = w_wr && (w_idx == c_PRESCALE);
    assign w_wr_cmp  = w_wr && (w_idx == c_COMPARE);
    assign w_wr_cnt  = w_wr && (w_idx == c_COUNT);
    assign w_wr_sts  = w_wr && (w_idx == c_STATUS);

    assign w_tick     = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_match_ev = w_tick && (r_count == r_compare);

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_compare  <= '0;
            r_count    <= '0;
            r_match    <= 1'b0;
            r_pcnt     <= '0;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= w_merged[3:0];
            // One-shot disable overrides any same-edge CTRL write.
            if (w_match_ev && r_ctrl[2])
                r_ctrl[0] <= 1'b0;

            if (w_wr_pre)
                r_prescale <= w_merged[PRESCALE_W-1:0];
            if (w_wr_cmp)
                r_compare <= w_merged;

            if (w_wr_ctrl || w_wr_pre)
                r_pcnt <= '0;
            else if (r_ctrl[0])
                r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);

            if (w_wr_cnt)
                r_count <= w_merged;
            else if (w_tick)
                r_count <= (w_match_ev && r_ctrl[1]) ? 32'h0 : r_count + 32'h1;

            if (w_match_ev)
                r_match <= 1'b1;
            else if (w_wr_sts && w_w1c[0])
                r_match <= 1'b0;
        end
    end

`ifdef LB_TIMER_CAPTURE_EN
    logic [2:0]  r_cap_sync;
    logic [31:0] r_capture;
    logic        r_cap;
    logic        w_cap_edge;

    // Two synchroniser flops plus one edge-history flop.
    assign w_cap_edge = r_cap_sync[1] & ~r_cap_sync[2];

    always_ff @(posedge lb_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_sync <= '0;
            r_capture  <= '0;
            r_cap      <= 1'b0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], cap_in};
            if (w_cap_edge && r_ctrl[0]) begin
                r_capture <= r_count;
                r_cap     <= 1'b1;
            end else if (w_wr_sts && w_w1c[1]) begin
                r_cap     <= 1'b0;
            end
        end
    end

    assign w_capture  = r_capture;
    assign w_cap_flag = r_cap;
`else
    assign w_capture  = 32'h0;
    assign w_cap_flag = 1'b0;
`endif

    assign irq = (r_match | w_cap_flag) & r_ctrl[3];

endmodule

`default_nettype wire

// File: tb/tb_lb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_timer
// Brief    : Self-checking bench for lb_timer: register access table plus
//            directed timing sequences (capture checks need LB_TIMER_CAPTURE_EN).
// Revision : 1.0 - initial release
// ============================================================================

module tb_lb_timer;
    import lb_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] exp;
    } vec_t;

    logic        lb_clk = 1'b0;
    logic        rst_n  = 1'b0;
    lb_slave_t   bus;
    logic [31:0] rdata;
    logic        irq;
`ifdef LB_TIMER_CAPTURE_EN
    logic        cap_in = 1'b0;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vq[$];

    always #5 lb_clk = ~lb_clk;

    lb_timer #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(16)
    ) dut (
        .lb_clk(lb_clk),
        .rst_n (rst_n),
        .bus   (bus),
`ifdef LB_TIMER_CAPTURE_EN
        .cap_in(cap_in),
`endif
        .rdata (rdata),
        .irq   (irq)
    );

    function automatic logic [15:0] ra(input logic [7:0] off);
        return BASE[15:0] + {8'h0, off};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the commit edge.
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] w);
        bus.ren         = 1'b0;
        bus.addr        = a;
        bus.wdata       = d;
        bus.write_width = w;
        bus.wen         = 1'b1;
        @(negedge lb_clk);
        bus.wen         = 1'b0;
    endtask

    // Combinational read with no clock edge consumed.
    task automatic peek(input logic [15:0] a, output logic [31:0] d);
        bus.wen  = 1'b0;
        bus.addr = a;
        bus.ren  = 1'b1;
        #1;
        d        = rdata;
        bus.ren  = 1'b0;
    endtask

    task automatic addv(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [1:0] wd, input logic [31:0] e);
        vec_t v;
        v.wr    = w;
        v.addr  = a;
        v.data  = d;
        v.width = wd;
        v.exp   = e;
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n_edge;
        logic [31:0] seq_exp [7];

        bus   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge lb_clk);
        rst_n = 1'b1;
        @(negedge lb_clk);
        check("irq_reset", 32'(irq), 32'h0);

        // Register access table; the timer stays disabled throughout.
        for (int i = 0; i < 8; i++)
            addv(1'b0, ra(8'(i * 4)), 32'h0, 2'd2, 32'h0);
        addv(1'b1, ra(8'h08), 32'h1122_3344, 2'd2, 32'h0);
        addv(1'b0, ra(8'h08), 32'h0,         2'd2, 32'h1122_3344);
        addv(1'b0, ra(8'h28), 32'h0,         2'd2, 32'h0);
        addv(1'b1, ra(8'h09), 32'h0000_00AB, 2'd0, 32'h0);
        addv(1'b0, ra(8'h08), 32'h0,         2'd2, 32'h1122_AB44);
        addv(1'b1, ra(8'h0A), 32'h0000_BEEF, 2'd1, 32'h0);
        addv(1'b0, ra(8'h08), 32'h0,         2'd2, 32'hBEEF_AB44);
        addv(1'b1, ra(8'h09), 32'h0000_1234, 2'd1, 32'h0);
        addv(1'b0, ra(8'h08), 32'h0,         2'd2, 32'hBEEF_AB44);
        addv(1'b1, ra(8'h08), 32'hCAFE_F00D, 2'd3, 32'h0);
        addv(1'b0, ra(8'h08), 32'h0,         2'd2, 32'hCAFE_F00D);
        addv(1'b1, ra(8'h04), 32'h1234_5678, 2'd2, 32'h0);
        addv(1'b0, ra(8'h04), 32'h0,         2'd2, 32'h0000_5678);
        addv(1'b1, ra(8'h14), 32'hFFFF_FFFF, 2'd2, 32'h0);
        addv(1'b0, ra(8'h14), 32'h0,         2'd2, 32'h0);
        addv(1'b1, ra(8'h18), 32'hFFFF_FFFF, 2'd2, 32'h0);
        addv(1'b0, ra(8'h18), 32'h0,         2'd2, 32'h0);
        addv(1'b1, ra(8'h01), 32'h0000_00FF, 2'd0, 32'h0);
        addv(1'b0, ra(8'h00), 32'h0,         2'd2, 32'h0);
        addv(1'b1, ra(8'h00), 32'h0000_000E, 2'd2, 32'h0);
        addv(1'b0, ra(8'h00), 32'h0,         2'd2, 32'h0000_000E);
        addv(1'b1, ra(8'h00), 32'h0,         2'd2, 32'h0);
        addv(1'b1, ra(8'h0C), 32'h1234_5678, 2'd2, 32'h0);
        addv(1'b0, ra(8'h0C), 32'h0,         2'd2, 32'h1234_5678);
        addv(1'b0, ra(8'h10), 32'h0,         2'd2, 32'h0);

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                wr(vq[i].addr, vq[i].data, vq[i].width);
            end else begin
                peek(vq[i].addr, d);
                check($sformatf("vec%0d_addr%04h", i, vq[i].addr), d, vq[i].exp);
                @(negedge lb_clk);
            end
        end

        bus.addr = ra(8'h08);
        bus.ren  = 1'b0;
        bus.wen  = 1'b0;
        #1;
        check("rdata_idle_ren0", rdata, 32'h0);
        @(negedge lb_clk);

        // Prescaled count: PRESCALE=2 ticks every 3 cycles, match at COUNT==5.
        wr(ra(8'h0C), 32'h0, 2'd2);
        wr(ra(8'h08), 32'h5, 2'd2);
        wr(ra(8'h04), 32'h2, 2'd2);
        wr(ra(8'h00), 32'h9, 2'd2);
        n_edge = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge lb_clk);
            if (irq) begin
                n_edge = k;
                break;
            end
        end
        check("irq_match_latency", 32'(n_edge), 32'd18);
        peek(ra(8'h0C), d);
        check("count_after_match", d, 32'h6);
        peek(ra(8'h10), d);
        check("status_match", d, 32'h1);
        wr(ra(8'h00), 32'h0, 2'd2);
        check("irq_gated_off", 32'(irq), 32'h0);
        wr(ra(8'h10), 32'h1, 2'd2);
        peek(ra(8'h10), d);
        check("status_w1c", d, 32'h0);

        // Auto-reload with one-shot at PRESCALE=0.
        wr(ra(8'h0C), 32'h0, 2'd2);
        wr(ra(8'h08), 32'h3, 2'd2);
        wr(ra(8'h04), 32'h0, 2'd2);
        wr(ra(8'h00), 32'hF, 2'd2);
        seq_exp = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            peek(ra(8'h0C), d);
            check($sformatf("oneshot_count%0d", i), d, seq_exp[i]);
            @(negedge lb_clk);
        end
        peek(ra(8'h00), d);
        check("oneshot_en_cleared", d, 32'hE);
        check("oneshot_irq", 32'(irq), 32'h1);
        wr(ra(8'h10), 32'h1, 2'd0);
        check("oneshot_irq_w1c", 32'(irq), 32'h0);

        // COUNT write on a tick edge, then natural wrap.
        wr(ra(8'h00), 32'h0, 2'd2);
        wr(ra(8'h08), 32'h10, 2'd2);
        wr(ra(8'h0C), 32'hFFFF_FFFF, 2'd2);
        wr(ra(8'h00), 32'h9, 2'd2);
        wr(ra(8'h0C), 32'h100, 2'd2);
        peek(ra(8'h0C), d);
        check("count_write_wins", d, 32'h100);
        wr(ra(8'h0C), 32'hFFFF_FFFF, 2'd2);
        peek(ra(8'h0C), d);
        check("count_set_max", d, 32'hFFFF_FFFF);
        @(negedge lb_clk);
        peek(ra(8'h0C), d);
        check("count_wrap", d, 32'h0);
        peek(ra(8'h10), d);
        check("wrap_no_match", d, 32'h0);
        check("wrap_no_irq", 32'(irq), 32'h0);
        wr(ra(8'h00), 32'h0, 2'd2);

`ifdef LB_TIMER_CAPTURE_EN
        wr(ra(8'h00), 32'h1, 2'd2);
        wr(ra(8'h0C), 32'h40, 2'd2);
        cap_in = 1'b1;
        @(negedge lb_clk);
        @(negedge lb_clk);
        cap_in = 1'b0;
        @(negedge lb_clk);
        peek(ra(8'h14), d);
        check("capture_value", d, 32'h42);
        peek(ra(8'h10), d);
        check("capture_flag", d, 32'h2);
        wr(ra(8'h00), 32'h0, 2'd2);
`endif

        // Asynchronous reset in the middle of counting.
        wr(ra(8'h08), 32'h77, 2'd2);
        wr(ra(8'h00), 32'h9, 2'd2);
        repeat (5) @(negedge lb_clk);
        #1;
        rst_n = 1'b0;
        peek(ra(8'h0C), d);
        check("reset_count", d, 32'h0);
        peek(ra(8'h00), d);
        check("reset_ctrl", d, 32'h0);
        peek(ra(8'h08), d);
        check("reset_compare", d, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        @(negedge lb_clk);
        rst_n = 1'b1;
        @(negedge lb_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
